// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the Wishbone-to-SPI-flash read-in-place bridge.
package spi_flash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        ACK,
        GAP,
        ERR
    } state_t;

    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam int         FRAME_BITS = 64;
    localparam int         ADDR_BITS  = 24;

    // Flash streams bytes in ascending address order; the bus word is little-endian.
    function automatic logic [31:0] swap_bytes(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/wb_spi_flash_xip_if.sv
// Wishbone slave port of the SPI-flash read-in-place bridge.
interface wb_spi_flash_xip_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_spi_flash_sck_gen.sv
// SPI mode-0 clock generator: CLK_DIV-cycle half periods, idles low when disabled.
module wb_spi_flash_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic sck,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] half_cnt;
    logic          half_done;

    // Strobes mark the clk edge on which sck toggles, so the FSM acts in lockstep with it.
    assign half_done = en && (half_cnt == CW'(CLK_DIV - 1));
    assign rise_stb  = half_done && !sck;
    assign fall_stb  = half_done && sck;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            half_cnt <= '0;
            sck      <= 1'b0;
        end else if (!en) begin
            half_cnt <= '0;
            sck      <= 1'b0;
        end else if (half_done) begin
            half_cnt <= '0;
            sck      <= ~sck;
        end else begin
            half_cnt <= half_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wb_spi_flash_xip.sv
// Read-only Wishbone slave mapping SPI NOR flash into the address space; one READ frame per access.
// IDLE wait for request | SETUP cs_n low, first MOSI bit | SHIFT 64 SCK periods | HOLD sck low, cs_n low
// ACK return word | GAP cs_n high recovery | ERR one-cycle write error
module wb_spi_flash_xip
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    wb_spi_flash_xip_if.slave  wb,
    output logic               spi_sck_o,
    output logic               spi_cs_n_o,
    output logic               spi_mosi_o,
    input  logic               spi_miso_i
);

    localparam int TMR_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int TW      = $clog2(TMR_MAX + 1);
    localparam int BW      = $clog2(FRAME_BITS);

    state_t                state;
    logic [FRAME_BITS-1:0] shift_q;
    logic [31:0]           rx_q;
    logic [BW-1:0]         bits_left;
    logic [TW-1:0]         tmr;
    logic                  req;
    logic                  sck_rise;
    logic                  sck_fall;
    logic                  unused_bus_bits;

    assign req = wb.wb_cyc_i && wb.wb_stb_i;
    assign unused_bus_bits = ^{wb.wb_dat_i, wb.wb_sel_i, wb.wb_adr_i[31:ADDR_BITS], wb.wb_adr_i[1:0]};

    wb_spi_flash_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (state == SHIFT),
        .sck      (spi_sck_o),
        .rise_stb (sck_rise),
        .fall_stb (sck_fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            shift_q     <= '0;
            rx_q        <= '0;
            bits_left   <= '0;
            tmr         <= '0;
            spi_cs_n_o  <= 1'b1;
            spi_mosi_o  <= 1'b0;
            wb.wb_ack_o <= 1'b0;
            wb.wb_err_o <= 1'b0;
            wb.wb_dat_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && wb.wb_we_i) begin
                        state       <= ERR;
                        wb.wb_err_o <= 1'b1;
                    end else if (req) begin
                        state      <= SETUP;
                        shift_q    <= {CMD_READ, wb.wb_adr_i[ADDR_BITS-1:2], 2'b00, 32'h0};
                        spi_cs_n_o <= 1'b0;
                        spi_mosi_o <= CMD_READ[7];
                        tmr        <= TW'(CLK_DIV - 1);
                    end
                end
                ERR: begin
                    wb.wb_err_o <= 1'b0;
                    state       <= IDLE;
                end
                SETUP: begin
                    if (tmr == '0) begin
                        state     <= SHIFT;
                        bits_left <= BW'(FRAME_BITS - 1);
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                SHIFT: begin
                    // Only the last 32 samples survive in rx_q; those are the data bytes.
                    if (sck_rise) begin
                        rx_q <= {rx_q[30:0], spi_miso_i};
                    end
                    if (sck_fall) begin
                        shift_q    <= {shift_q[FRAME_BITS-2:0], 1'b0};
                        spi_mosi_o <= shift_q[FRAME_BITS-2];
                        if (bits_left == '0) begin
                            state <= HOLD;
                            tmr   <= TW'(CLK_DIV - 1);
                        end else begin
                            bits_left <= bits_left - 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (tmr == '0) begin
                        state       <= ACK;
                        spi_cs_n_o  <= 1'b1;
                        spi_mosi_o  <= 1'b0;
                        wb.wb_dat_o <= swap_bytes(rx_q);
                        wb.wb_ack_o <= req;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ACK: begin
                    wb.wb_ack_o <= 1'b0;
                    state       <= GAP;
                    tmr         <= TW'(CS_GAP - 1);
                end
                GAP: begin
                    if (tmr == '0) begin
                        state <= IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_spi_flash_xip.sv
// Directed bench for wb_spi_flash_xip: two instances (CLK_DIV=2 and CLK_DIV=1) each talking to a flash model.
module tb_wb_spi_flash_xip;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h11;
            24'h000101: return 8'h22;
            24'h000102: return 8'h33;
            24'h000103: return 8'h44;
            default:    return a[7:0] + 8'hA0;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int CD = (g == 0) ? 2 : 1;
        localparam int CG = (g == 0) ? 2 : 3;

        logic        rst_n   = 1'b0;
        logic        sck;
        logic        cs_n;
        logic        mosi;
        logic        miso    = 1'b0;
        int          bit_cnt = 0;
        int          rises   = 0;
        logic [31:0] hdr     = '0;

        wb_spi_flash_xip_if bus ();

        wb_spi_flash_xip #(
            .CLK_DIV (CD),
            .CS_GAP  (CG)
        ) u_dut (
            .clk        (clk),
            .reset_n    (rst_n),
            .wb         (bus.slave),
            .spi_sck_o  (sck),
            .spi_cs_n_o (cs_n),
            .spi_mosi_o (mosi),
            .spi_miso_i (miso)
        );

        always @(negedge cs_n) begin
            bit_cnt = 0;
            rises   = 0;
        end

        always @(posedge sck) begin
            if (!cs_n) begin
                if (bit_cnt < 32) hdr = {hdr[30:0], mosi};
                bit_cnt = bit_cnt + 1;
                rises   = rises + 1;
            end
        end

        // Mode-0 flash: data bits change on the falling edge after the 32 header bits.
        always @(negedge sck) begin
            logic [7:0] b;
            if (!cs_n && bit_cnt >= 32 && bit_cnt < 64) begin
                b    = flash_byte(hdr[23:0] + 24'((bit_cnt - 32) / 8));
                miso = b[7 - ((bit_cnt - 32) % 8)];
            end
        end
    end

    task automatic drive(input int d, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat);
        if (d == 0) begin
            g_dut[0].bus.wb_cyc_i = cyc;
            g_dut[0].bus.wb_stb_i = stb;
            g_dut[0].bus.wb_we_i  = we;
            g_dut[0].bus.wb_adr_i = adr;
            g_dut[0].bus.wb_dat_i = dat;
            g_dut[0].bus.wb_sel_i = 4'hF;
        end else begin
            g_dut[1].bus.wb_cyc_i = cyc;
            g_dut[1].bus.wb_stb_i = stb;
            g_dut[1].bus.wb_we_i  = we;
            g_dut[1].bus.wb_adr_i = adr;
            g_dut[1].bus.wb_dat_i = dat;
            g_dut[1].bus.wb_sel_i = 4'hF;
        end
    endtask

    task automatic set_rst(input int d, input logic v);
        if (d == 0) g_dut[0].rst_n = v;
        else        g_dut[1].rst_n = v;
    endtask

    function automatic logic get_ack(input int d);
        return (d == 0) ? g_dut[0].bus.wb_ack_o : g_dut[1].bus.wb_ack_o;
    endfunction
    function automatic logic get_err(input int d);
        return (d == 0) ? g_dut[0].bus.wb_err_o : g_dut[1].bus.wb_err_o;
    endfunction
    function automatic logic [31:0] get_dat(input int d);
        return (d == 0) ? g_dut[0].bus.wb_dat_o : g_dut[1].bus.wb_dat_o;
    endfunction
    function automatic logic get_cs(input int d);
        return (d == 0) ? g_dut[0].cs_n : g_dut[1].cs_n;
    endfunction
    function automatic logic get_sck(input int d);
        return (d == 0) ? g_dut[0].sck : g_dut[1].sck;
    endfunction
    function automatic logic get_mosi(input int d);
        return (d == 0) ? g_dut[0].mosi : g_dut[1].mosi;
    endfunction
    function automatic logic [31:0] get_hdr(input int d);
        return (d == 0) ? g_dut[0].hdr : g_dut[1].hdr;
    endfunction
    function automatic int get_rises(input int d);
        return (d == 0) ? g_dut[0].rises : g_dut[1].rises;
    endfunction

    // Issues one read; n counts cycles after the IDLE sampling cycle. drop_at=0 keeps stb up until ack.
    task automatic do_read(input int d, input logic [31:0] adr, input int drop_at, input int max_cyc,
                           output int ack_cyc, output int ack_cnt, output logic [31:0] dat);
        ack_cyc = -1;
        ack_cnt = 0;
        dat     = '0;
        @(negedge clk);
        drive(d, 1'b1, 1'b1, 1'b0, adr, 32'h0);
        for (int n = 1; n <= max_cyc; n++) begin
            @(negedge clk);
            if (get_ack(d)) begin
                ack_cnt++;
                if (ack_cyc < 0) begin
                    ack_cyc = n;
                    dat     = get_dat(d);
                end
            end
            if (n == drop_at || ack_cyc == n) drive(d, 1'b0, 1'b0, 1'b0, adr, 32'h0);
        end
        drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total_cnt++;
            if (get_cs(d) !== 1'b1) $display("FAIL reset_cs_n[%0d]: got %b, expected 1", d, get_cs(d));
            else pass_cnt++;
            total_cnt++;
            if (get_sck(d) !== 1'b0) $display("FAIL reset_sck[%0d]: got %b, expected 0", d, get_sck(d));
            else pass_cnt++;
            total_cnt++;
            if (get_mosi(d) !== 1'b0) $display("FAIL reset_mosi[%0d]: got %b, expected 0", d, get_mosi(d));
            else pass_cnt++;
            total_cnt++;
            if (get_ack(d) !== 1'b0) $display("FAIL reset_ack[%0d]: got %b, expected 0", d, get_ack(d));
            else pass_cnt++;
            total_cnt++;
            if (get_err(d) !== 1'b0) $display("FAIL reset_err[%0d]: got %b, expected 0", d, get_err(d));
            else pass_cnt++;
            total_cnt++;
            if (get_dat(d) !== 32'h0) $display("FAIL reset_dat[%0d]: got %h, expected 00000000", d, get_dat(d));
            else pass_cnt++;
        end
        set_rst(0, 1'b1);
        set_rst(1, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_read();
        int ack_cyc, ack_cnt;
        logic [31:0] dat;
        do_read(0, 32'h0000_0100, 0, 300, ack_cyc, ack_cnt, dat);
        total_cnt++;
        if (ack_cyc != 261) $display("FAIL basic_ack_cycle: got %0d, expected 261", ack_cyc);
        else pass_cnt++;
        total_cnt++;
        if (ack_cnt != 1) $display("FAIL basic_ack_count: got %0d, expected 1", ack_cnt);
        else pass_cnt++;
        total_cnt++;
        if (dat !== 32'h4433_2211) $display("FAIL basic_data: got %h, expected 44332211", dat);
        else pass_cnt++;
        total_cnt++;
        if (get_hdr(0) !== 32'h0300_0100) $display("FAIL basic_mosi_frame: got %h, expected 03000100", get_hdr(0));
        else pass_cnt++;
        total_cnt++;
        if (get_rises(0) != 64) $display("FAIL basic_sck_rises: got %0d, expected 64", get_rises(0));
        else pass_cnt++;
        total_cnt++;
        if (get_dat(0) !== 32'h4433_2211) $display("FAIL basic_dat_hold: got %h, expected 44332211", get_dat(0));
        else pass_cnt++;
    endtask

    task automatic test_write_error();
        bit saw_ack = 0, saw_cs = 0, saw_sck = 0;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF);
        @(negedge clk);
        total_cnt++;
        if (get_err(0) !== 1'b1) $display("FAIL write_err_cycle1: got %b, expected 1", get_err(0));
        else pass_cnt++;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        total_cnt++;
        if (get_err(0) !== 1'b0) $display("FAIL write_err_cycle2: got %b, expected 0", get_err(0));
        else pass_cnt++;
        for (int n = 0; n < 20; n++) begin
            if (get_ack(0) !== 1'b0) saw_ack = 1;
            if (get_cs(0) !== 1'b1) saw_cs = 1;
            if (get_sck(0) !== 1'b0) saw_sck = 1;
            @(negedge clk);
        end
        total_cnt++;
        if (saw_ack) $display("FAIL write_no_ack: got ack asserted, expected none");
        else pass_cnt++;
        total_cnt++;
        if (saw_cs || saw_sck) $display("FAIL write_no_spi: got cs_n_low=%0d sck_high=%0d, expected 0 0", saw_cs, saw_sck);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int acks = 0, gap_hi = 0;
        bit counting = 0;
        logic [31:0] d0 = '0, d1 = '0;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int n = 1; n <= 700 && acks < 2; n++) begin
            @(negedge clk);
            if (counting) begin
                if (get_cs(0)) gap_hi++;
                else counting = 0;
            end
            if (get_ack(0)) begin
                acks++;
                if (acks == 1) begin
                    d0       = get_dat(0);
                    counting = 1;
                    gap_hi   = 1;
                    drive(0, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
                end else begin
                    d1 = get_dat(0);
                    drive(0, 1'b0, 1'b0, 1'b0, 32'h4, 32'h0);
                end
            end
        end
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (6) @(negedge clk);
        total_cnt++;
        if (acks != 2) $display("FAIL b2b_ack_count: got %0d, expected 2", acks);
        else pass_cnt++;
        total_cnt++;
        if (d0 !== 32'hA3A2_A1A0) $display("FAIL b2b_data0: got %h, expected a3a2a1a0", d0);
        else pass_cnt++;
        total_cnt++;
        if (d1 !== 32'hA7A6_A5A4) $display("FAIL b2b_data1: got %h, expected a7a6a5a4", d1);
        else pass_cnt++;
        total_cnt++;
        if (gap_hi < 2) $display("FAIL b2b_cs_gap: got %0d cycles high, expected >= 2", gap_hi);
        else pass_cnt++;
    endtask

    task automatic test_addr_wrap();
        int ack_cyc, ack_cnt;
        logic [31:0] dat;
        do_read(0, 32'h10FF_FFFE, 0, 300, ack_cyc, ack_cnt, dat);
        total_cnt++;
        if (get_hdr(0) !== 32'h03FF_FFFC) $display("FAIL wrap_mosi_frame: got %h, expected 03fffffc", get_hdr(0));
        else pass_cnt++;
        total_cnt++;
        if (ack_cnt != 1 || dat !== 32'h9F9E_9D9C)
            $display("FAIL wrap_data: got %h (acks %0d), expected 9f9e9d9c (acks 1)", dat, ack_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        int ack_cyc, ack_cnt;
        logic [31:0] dat;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        repeat (50) @(negedge clk);
        set_rst(0, 1'b0);
        #1;
        total_cnt++;
        if (get_cs(0) !== 1'b1 || get_sck(0) !== 1'b0 || get_ack(0) !== 1'b0)
            $display("FAIL midreset_outputs: got cs_n=%b sck=%b ack=%b, expected 1 0 0", get_cs(0), get_sck(0), get_ack(0));
        else pass_cnt++;
        total_cnt++;
        if (get_dat(0) !== 32'h0) $display("FAIL midreset_dat: got %h, expected 00000000", get_dat(0));
        else pass_cnt++;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        set_rst(0, 1'b1);
        repeat (2) @(negedge clk);
        do_read(0, 32'h0000_0008, 0, 300, ack_cyc, ack_cnt, dat);
        total_cnt++;
        if (ack_cyc != 261) $display("FAIL midreset_ack_cycle: got %0d, expected 261", ack_cyc);
        else pass_cnt++;
        total_cnt++;
        if (dat !== 32'hABAA_A9A8) $display("FAIL midreset_data: got %h, expected abaaa9a8", dat);
        else pass_cnt++;
    endtask

    task automatic test_clk_div1();
        int ack_cyc, ack_cnt;
        logic [31:0] dat;
        do_read(1, 32'h0000_0100, 0, 160, ack_cyc, ack_cnt, dat);
        total_cnt++;
        if (ack_cyc != 131) $display("FAIL div1_ack_cycle: got %0d, expected 131", ack_cyc);
        else pass_cnt++;
        total_cnt++;
        if (dat !== 32'h4433_2211) $display("FAIL div1_data: got %h, expected 44332211", dat);
        else pass_cnt++;
        total_cnt++;
        if (get_rises(1) != 64) $display("FAIL div1_sck_rises: got %0d, expected 64", get_rises(1));
        else pass_cnt++;
        do_read(1, 32'h0000_0004, 100, 160, ack_cyc, ack_cnt, dat);
        total_cnt++;
        if (ack_cnt != 0) $display("FAIL div1_dropped_ack: got %0d acks, expected 0", ack_cnt);
        else pass_cnt++;
        total_cnt++;
        if (get_dat(1) !== 32'hA7A6_A5A4) $display("FAIL div1_dropped_dat: got %h, expected a7a6a5a4", get_dat(1));
        else pass_cnt++;
        do_read(1, 32'h0000_0008, 0, 160, ack_cyc, ack_cnt, dat);
        total_cnt++;
        if (ack_cyc != 131 || dat !== 32'hABAA_A9A8)
            $display("FAIL div1_next_read: got cycle %0d data %h, expected 131 abaaa9a8", ack_cyc, dat);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_write_error();
        test_back_to_back();
        test_addr_wrap();
        test_reset_mid_frame();
        test_clk_div1();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
